// File: rtl/mm_uart_fifo_if.sv
// Memory-mapped I/O bus bundle for mm_uart_fifo.
// The CPU side (master) drives strobes, address and write data;
// the peripheral (slave) returns registered read data.
interface mm_uart_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    readEnable;
  logic                    writeEnable;
  logic [DATA_WIDTH/8-1:0] writeByteEnable;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   writeData;
  logic [DATA_WIDTH-1:0]   readData;

  modport master (
    output readEnable, writeEnable, writeByteEnable, address, writeData,
    input  readData
  );

  modport slave (
    input  readEnable, writeEnable, writeByteEnable, address, writeData,
    output readData
  );
endinterface

// File: rtl/mm_uart_fifo.sv
// mm_uart_fifo: memory-mapped UART with TX/RX FIFOs, STATUS register and
// sticky error flags. Frame is 8N1 by default.
// Optional feature: define UART_PARITY_EN for 8E1 frames (even parity sent
// and checked after bit 7; mismatch sets par_err and drops the byte).
// Register window: BASE+0 RXDATA (R), BASE+4 TXDATA (W), BASE+8 STATUS (R).
module mm_uart_fifo #(
  parameter int                    CLOCK_FREQUENCY = 25000000,
  parameter int                    BAUD_RATE       = 115200,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'h9000_0010,
  parameter int                    TX_FIFO_DEPTH   = 4,
  parameter int                    RX_FIFO_DEPTH   = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          uart_rx,
  output logic          uart_tx,
  mm_uart_fifo_if.slave bus
);

  localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  localparam logic [ADDR_WIDTH-1:0] RXDATA_ADDR = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] TXDATA_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(8);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // ---------------- bus decode ----------------
  logic rd_rx, rd_status, wr_tx;
  assign rd_rx     = bus.readEnable && (bus.address == RXDATA_ADDR);
  assign rd_status = bus.readEnable && (bus.address == STATUS_ADDR);
  assign wr_tx     = bus.writeEnable && bus.writeByteEnable[0] && (bus.address == TXDATA_ADDR);

  // Bus bits this block deliberately ignores (only byte lane 0 carries TX data).
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.writeData[DATA_WIDTH-1:8], bus.writeByteEnable[DATA_WIDTH/8-1:1]};

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [TX_FIFO_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_count == TX_CW'(TX_FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = wr_tx && !tx_full;  // full is judged before any same-cycle pop

  // TX storage write.
  // NOTE: FIFO storage is deliberately not reset; pointers and count decide which entries are live, and a reset-free array can map onto RAM.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.writeData[7:0];
  end

  // TX FIFO pointers and occupancy.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t  tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       tx_line_n, tx_load, tx_last;
`ifdef UART_PARITY_EN
  logic       tx_par, tx_par_n;
`endif

  assign tx_last = (tx_cnt == BIT_LAST);

  // TX state register and registered serial output.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state: bit timing, shifting, FIFO pop (from IDLE or straight out of STOP).
  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    tx_line_n  = 1'b1;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    if (tx_state != TX_IDLE) tx_cnt_n = tx_last ? '0 : tx_cnt + CNT_W'(1);
    case (tx_state)
      TX_IDLE:  tx_load = !tx_empty;
      TX_START: if (tx_last) tx_state_n = TX_DATA;
      TX_DATA: begin
        if (tx_last) begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
`ifdef UART_PARITY_EN
          if (tx_bit == 3'd7) tx_state_n = TX_PARITY;
`else
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_last) tx_state_n = TX_STOP;
`endif
      TX_STOP: begin
        if (tx_last) begin
          tx_state_n = TX_IDLE;
          tx_load    = !tx_empty;  // chain the next frame with no idle gap
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_n = TX_START;
      tx_cnt_n   = '0;
      tx_bit_n   = '0;
      tx_shift_n = tx_mem[tx_rd_ptr];
`ifdef UART_PARITY_EN
      tx_par_n   = ^tx_mem[tx_rd_ptr];
`endif
    end
    case (tx_state_n)
      TX_START:  tx_line_n = 1'b0;
      TX_DATA:   tx_line_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_line_n = tx_par_n;
`endif
      default:   tx_line_n = 1'b1;
    endcase
  end

  // ---------------- RX synchroniser ----------------
  logic rx_s1, rx_s2, rx_prev;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t  rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rx_last, rx_half, rx_byte_ok, frame_err_set, par_err_set;
`ifdef UART_PARITY_EN
  logic       rx_par_bad, rx_par_bad_n;
`endif

  assign rx_last = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  // RX state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
`ifdef UART_PARITY_EN
      rx_par_bad <= rx_par_bad_n;
`endif
    end
  end

  // RX next state: start validation at half bit, mid-bit sampling, stop/parity verdict.
  always_comb begin
    rx_state_n    = rx_state;
    rx_cnt_n      = rx_cnt;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_byte_ok    = 1'b0;
    frame_err_set = 1'b0;
    par_err_set   = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_n  = rx_par_bad;
`endif
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        rx_cnt_n = rx_cnt + CNT_W'(1);
        if (rx_half) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;  // high at mid-start is a glitch
        end
      end
      RX_DATA: begin
        rx_cnt_n = rx_last ? '0 : rx_cnt + CNT_W'(1);
        if (rx_last) begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
`ifdef UART_PARITY_EN
          if (rx_bit == 3'd7) rx_state_n = RX_PARITY;
`else
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        rx_cnt_n = rx_last ? '0 : rx_cnt + CNT_W'(1);
        if (rx_last) begin
          rx_par_bad_n = (^rx_shift) ^ rx_s2;
          rx_state_n   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        rx_cnt_n = rx_last ? '0 : rx_cnt + CNT_W'(1);
        if (rx_last) begin
          if (!rx_s2) begin
            frame_err_set = 1'b1;
            rx_state_n    = RX_BREAK;
          end else begin
            rx_state_n = RX_IDLE;
`ifdef UART_PARITY_EN
            if (rx_par_bad) par_err_set = 1'b1;
            else            rx_byte_ok  = 1'b1;
`else
            rx_byte_ok = 1'b1;
`endif
          end
        end
      end
      RX_BREAK: if (rx_s2) rx_state_n = RX_IDLE;  // wait for the line to return high
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem [RX_FIFO_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic             rx_full, rx_empty, rx_push, rx_pop, overrun_set;

  assign rx_full     = (rx_count == RX_CW'(RX_FIFO_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_pop      = rd_rx && !rx_empty;
  assign rx_push     = rx_byte_ok && (!rx_full || rx_pop);  // a same-cycle CPU pop makes room
  assign overrun_set = rx_byte_ok && rx_full && !rx_pop;

  // RX storage write.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  logic overrun, frame_err, par_err;

  // Sticky error flags: cleared by a STATUS read unless a new event lands in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      overrun   <= (overrun   && !rd_status) || overrun_set;
      frame_err <= (frame_err && !rd_status) || frame_err_set;
      par_err   <= (par_err   && !rd_status) || par_err_set;
    end
  end

  // ---------------- read path ----------------
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  tx_idle;

  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  // Read mux for the addressed register; unmapped addresses read as zero.
  always_comb begin
    rd_value = '0;
    if (bus.address == RXDATA_ADDR) begin
      if (!rx_empty) rd_value[8:0] = {1'b1, rx_mem[rx_rd_ptr]};
    end else if (bus.address == STATUS_ADDR) begin
      rd_value[5:0] = {par_err, frame_err, overrun, tx_idle, !tx_full, !rx_empty};
    end
  end

  // Registered read data, held while no read is strobed.
  always_ff @(posedge clock) begin
    if (!reset)              bus.readData <= '0;
    else if (bus.readEnable) bus.readData <= rd_value;
  end

endmodule

// File: tb/tb_mm_uart_fifo.sv
// Self-checking bench for mm_uart_fifo at default parameters.
// Expected RX words go into a scoreboard queue when TX bytes are written (or
// frames are driven) and are popped when RXDATA is read. A serial monitor
// decodes uart_tx independently to check frame content and timing.
`timescale 1ns/1ps
module tb_mm_uart_fifo;

  localparam int BAUD = 25000000 / 115200;  // 217
`ifdef UART_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FRAME = FBITS * BAUD;
  localparam logic [31:0] RXDATA = 32'h9000_0010;
  localparam logic [31:0] TXDATA = 32'h9000_0014;
  localparam logic [31:0] STATUS = 32'h9000_0018;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic loop_en = 1'b1;
  logic tb_rx   = 1'b1;
  logic mon_chk = 1'b1;
  logic uart_tx, uart_rx;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q [$];
  int          start_q [$];
  logic [7:0]  mon_q [$];

  mm_uart_fifo_if bus ();

  assign uart_rx = loop_en ? uart_tx : tb_rx;

  mm_uart_fifo dut (
    .clock   (clock),
    .reset   (reset),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; the read is sampled at the next posedge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.readEnable = 1'b1;
    bus.address    = a;
    @(negedge clock);
    bus.readEnable = 1'b0;
    bus.address    = '0;
    d = bus.readData;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] v);
    bus.writeEnable     = 1'b1;
    bus.writeByteEnable = 4'hF;
    bus.address         = a;
    bus.writeData       = {24'h0, v};
    @(negedge clock);
    bus.writeEnable     = 1'b0;
    bus.writeByteEnable = 4'h0;
    bus.address         = '0;
  endtask

  task automatic wait_status_bit(input int b, input string tag, input int budget);
    logic [31:0] d;
    int n = 0;
    do begin
      bus_read(STATUS, d);
      n++;
    end while (!d[b] && n < budget);
    check(tag, {31'b0, d[b]}, 32'd1);
  endtask

  task automatic rx_read_expect(input string tag);
    logic [31:0] d, e;
    bus_read(RXDATA, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    check(tag, d, e);
  endtask

  task automatic wait_start(output int t0);
    int n = 0;
    while (start_q.size() == 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("tx_start_seen", {31'b0, start_q.size() != 0}, 32'd1);
    t0 = (start_q.size() != 0) ? start_q.pop_front() : cyc;
  endtask

  task automatic send_bits(input logic [10:0] f);
    for (int i = 0; i < FBITS; i++) begin
      tb_rx = f[i];
      idle(BAUD);
    end
    tb_rx = 1'b1;
    idle(2 * BAUD);
  endtask

  // Serial monitor: decodes uart_tx at mid-bit, records start cycle and byte.
  logic [7:0] mon_b;
  logic       mon_stop;
`ifdef UART_PARITY_EN
  logic       mon_par;
`endif
  initial forever begin
    @(negedge clock);
    if (reset && uart_tx === 1'b0) begin
      start_q.push_back(cyc);
      repeat (BAUD / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clock);
        mon_b[i] = uart_tx;
      end
`ifdef UART_PARITY_EN
      repeat (BAUD) @(negedge clock);
      mon_par = uart_tx;
      if (mon_chk) check("tx_parity", {31'b0, mon_par}, {31'b0, ^mon_b});
`endif
      repeat (BAUD) @(negedge clock);
      mon_stop = uart_tx;
      if (mon_chk) check("tx_stop", {31'b0, mon_stop}, 32'd1);
      mon_q.push_back(mon_b);
    end
  end

  initial begin
    #(950_000);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int t0;
    bus.readEnable      = 1'b0;
    bus.writeEnable     = 1'b0;
    bus.writeByteEnable = 4'h0;
    bus.address         = '0;
    bus.writeData       = '0;

    // 1. reset state
    idle(3);
    check("reset_readdata", bus.readData, 32'h0);
    check("reset_tx_line", {31'b0, uart_tx}, 32'd1);
    reset = 1'b1;
    idle(1);
    bus_read(STATUS, d);
    check("s1_status", d, 32'h6);
    rx_read_expect("s1_rx_empty");

    // 2. single byte loopback with exact frame length
    start_q.delete();
    mon_q.delete();
    bus_write(TXDATA, 8'hAB);
    exp_q.push_back(32'h1AB);
    wait_start(t0);
    while (cyc < t0 + FRAME - 1) @(negedge clock);
    bus_read(STATUS, d);
    check("s2_busy_last_stop_cycle", {31'b0, d[2]}, 32'd0);
    bus_read(STATUS, d);
    check("s2_idle_after_frame", {31'b0, d[2]}, 32'd1);
    check("s2_mon_count", mon_q.size(), 1);
    if (mon_q.size() != 0) check("s2_mon_byte", {24'h0, mon_q.pop_front()}, 32'hAB);
    wait_status_bit(0, "s2_rx_valid", 3000);
    rx_read_expect("s2_rx");
    rx_read_expect("s2_rx_empty");

    // 3. burst of 6 writes: 5 accepted, 6th dropped; back-to-back frames
    start_q.delete();
    mon_q.delete();
    for (int i = 0; i < 6; i++) bus_write(TXDATA, 8'h11 + 8'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h111 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      wait_status_bit(0, "s3_rx_valid", 3000);
      rx_read_expect("s3_rx");
    end
    wait_status_bit(2, "s3_tx_idle", 3000);
    check("s3_frames", start_q.size(), 5);
    for (int i = 0; i + 1 < start_q.size(); i++)
      check("s3_gap", {31'b0, (start_q[i+1] - start_q[i] >= FRAME) &&
                              (start_q[i+1] - start_q[i] <= FRAME + 1)}, 32'd1);
    for (int i = 0; i < mon_q.size(); i++)
      check("s3_mon_byte", {24'h0, mon_q[i]}, 32'h11 + 32'(i));
    rx_read_expect("s3_rx_empty");

    // 4. RX overrun: five bytes, no reads
    for (int i = 0; i < 5; i++) bus_write(TXDATA, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h1A0 + 32'(i));
    idle(5 * FRAME + 500);
    bus_read(STATUS, d);
    check("s4_overrun", {31'b0, d[3]}, 32'd1);
    check("s4_rx_nonempty", {31'b0, d[0]}, 32'd1);
    for (int i = 0; i < 4; i++) rx_read_expect("s4_rx");
    rx_read_expect("s4_rx_empty");
    bus_read(STATUS, d);
    check("s4_overrun_cleared", {31'b0, d[3]}, 32'd0);

    // 5. external line: framing error, parity error, then a good frame
    loop_en = 1'b0;
    idle(4);
`ifdef UART_PARITY_EN
    send_bits({1'b0, 1'b0, 8'h55, 1'b0});   // correct parity, stop held low
`else
    send_bits({1'b0, 1'b0, 8'h55, 1'b0});   // bit 10 unused; stop held low
`endif
    bus_read(STATUS, d);
    check("s5_frame_err", {31'b0, d[4]}, 32'd1);
    check("s5_frame_no_push", {31'b0, d[0]}, 32'd0);
    check("s5_no_par_err", {31'b0, d[5]}, 32'd0);
    rx_read_expect("s5_rx_empty");
`ifdef UART_PARITY_EN
    send_bits({1'b1, 1'b1, 8'h55, 1'b0});   // odd parity
    bus_read(STATUS, d);
    check("s5_par_err", {31'b0, d[5]}, 32'd1);
    check("s5_par_no_push", {31'b0, d[0]}, 32'd0);
    check("s5_par_no_frame_err", {31'b0, d[4]}, 32'd0);
    send_bits({1'b1, 1'b0, 8'h3C, 1'b0});
`else
    send_bits({1'b1, 1'b1, 8'h3C, 1'b0});
`endif
    exp_q.push_back(32'h13C);
    wait_status_bit(0, "s5_recover_valid", 3000);
    rx_read_expect("s5_recover_rx");
    loop_en = 1'b1;
    idle(4);

    // 6. reset in the middle of TX data bit 3
    mon_chk = 1'b0;
    start_q.delete();
    bus_write(TXDATA, 8'hA5);
    wait_start(t0);
    while (cyc < t0 + 4 * BAUD + BAUD / 2) @(negedge clock);
    check("s6_bit3_low", {31'b0, uart_tx}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("s6_tx_after_reset", {31'b0, uart_tx}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    bus_read(STATUS, d);
    check("s6_status", d, 32'h6);
    idle(FRAME + 500);
    bus_read(STATUS, d);
    check("s6_status_late", d, 32'h6);
    rx_read_expect("s6_rx_none");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
